// File: rtl/fifo_status.sv
// Synchronous FIFO with occupancy count, programmable almost-full/almost-empty
// flags, sticky overflow/underflow flags and a synchronous flush. r_data is show-ahead.
module fifo_status #(
  parameter int B      = 8,
  parameter int W      = 4,
  parameter int AF_LVL = 12,
  parameter int AE_LVL = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  input  logic         rd,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full,
  output logic         almost_empty,
  output logic         almost_full,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow
);

  localparam logic [W:0] DEPTH = (W+1)'(2**W);
  localparam logic [W:0] AF_C  = (W+1)'(AF_LVL);
  localparam logic [W:0] AE_C  = (W+1)'(AE_LVL);

  logic [B-1:0] mem [2**W];
  logic [W-1:0] w_ptr, r_ptr;
  logic [W:0]   count_next;
  logic         wr_ok, rd_ok;

  assign rd_ok  = rd & ~empty;
  // When full, a concurrent read frees the head slot, which is where w_ptr points.
  assign wr_ok  = wr & (~full | rd);
  assign r_data = mem[r_ptr];

  always_comb begin
    count_next = count;
    if (wr_ok && !rd_ok)
      count_next = count + (W+1)'(1);
    else if (rd_ok && !wr_ok)
      count_next = count - (W+1)'(1);
  end

  // Storage is not reset; writes are gated while reset is held or a flush is pending.
  always_ff @(posedge clk) begin
    if (reset && wr_ok && !clr)
      mem[w_ptr] <= w_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_ptr        <= '0;
      r_ptr        <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (clr) begin
      w_ptr        <= '0;
      r_ptr        <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_ok)
        w_ptr <= w_ptr + W'(1);
      if (rd_ok)
        r_ptr <= r_ptr + W'(1);
      count        <= count_next;
      empty        <= (count_next == '0);
      full         <= (count_next == DEPTH);
      almost_empty <= (count_next <= AE_C);
      almost_full  <= (count_next >= AF_C);
      if (wr && !wr_ok)
        overflow <= 1'b1;
      if (rd && empty)
        underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_status.sv
// Self-checking bench for fifo_status: hand-written vector table plus a queue-based
// behavioural model whose predictions go through a scoreboard queue.
module tb_fifo_status;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clr = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [7:0] w_data = '0;
  logic [7:0] r_data;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;
  logic [4:0] count;

  fifo_status #(.B(8), .W(4), .AF_LVL(12), .AE_LVL(2)) dut (
    .clk(clk), .reset(reset), .clr(clr), .wr(wr), .w_data(w_data), .rd(rd),
    .r_data(r_data), .empty(empty), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] cnt;
    logic [5:0] flg;   // {empty, full, almost_empty, almost_full, overflow, underflow}
    logic       hv;
    logic [7:0] head;
  } exp_t;

  typedef struct {
    logic       w, r, c;
    logic [7:0] d;
    logic [4:0] cnt;
    logic       chk_r;
    logic [7:0] rdat;
  } vec_t;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  logic [7:0] mq[$];
  logic m_ovf = 1'b0, m_unf = 1'b0;
  vec_t tv[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] dut_flags();
    return {empty, full, almost_empty, almost_full, overflow, underflow};
  endfunction

  task automatic model_step(input logic w, input logic r, input logic c, input logic [7:0] d);
    exp_t e;
    logic is_e, is_f, r_ok, w_ok;
    int   sz;
    if (c) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      is_e = (mq.size() == 0);
      is_f = (mq.size() == 16);
      r_ok = r && !is_e;
      w_ok = w && (!is_f || r);
      if (r && is_e) m_unf = 1'b1;
      if (w && !w_ok) m_ovf = 1'b1;
      if (r_ok) void'(mq.pop_front());
      if (w_ok) mq.push_back(d);
    end
    sz = mq.size();
    e.cnt  = 5'(sz);
    e.flg  = {sz == 0, sz == 16, sz <= 2, sz >= 12, m_ovf, m_unf};
    e.hv   = (sz > 0);
    e.head = (sz > 0) ? mq[0] : 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic score();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("count", 32'(count), 32'(e.cnt));
      chk("flags", 32'(dut_flags()), 32'(e.flg));
      if (e.hv) chk("r_data", 32'(r_data), 32'(e.head));
    end
  endtask

  task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
    @(negedge clk);
    wr = w; rd = r; clr = c; w_data = d;
    model_step(w, r, c, d);
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; clr = 1'b0;
    score();
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_count"}, 32'(count), 32'd0);
    chk({nm, "_flags"}, 32'(dut_flags()), 32'b101000);
  endtask

  initial begin
    tv[0] = '{1'b1, 1'b0, 1'b0, 8'h11, 5'd1, 1'b1, 8'h11};
    tv[1] = '{1'b1, 1'b0, 1'b0, 8'h22, 5'd2, 1'b1, 8'h11};
    tv[2] = '{1'b1, 1'b0, 1'b0, 8'h33, 5'd3, 1'b1, 8'h11};
    tv[3] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd2, 1'b1, 8'h22};
    tv[4] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd1, 1'b1, 8'h33};
    tv[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 8'h00};
    tv[6] = '{1'b1, 1'b1, 1'b0, 8'h5A, 5'd1, 1'b1, 8'h5A};
    tv[7] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 8'h00};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    reset = 1'b1;

    // Basic write/read, then simultaneous rd&wr on an empty FIFO.
    for (int i = 0; i < 8; i++) begin
      step(tv[i].w, tv[i].r, tv[i].c, tv[i].d);
      chk("tbl_count", 32'(count), 32'(tv[i].cnt));
      if (tv[i].chk_r) chk("tbl_r_data", 32'(r_data), 32'(tv[i].rdat));
    end
    chk("tbl_underflow", 32'(underflow), 32'd1);
    step(1'b0, 1'b0, 1'b1, 8'h00);

    // Fill to full, then an overflowing write.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 8'(i * 7 + 3));
    chk("full_flag", 32'(full), 32'd1);
    step(1'b1, 1'b0, 1'b0, 8'hEE);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    chk("ovf_head", 32'(r_data), 32'h03);

    // Full with rd&wr: count holds, head advances, new word ends up last.
    step(1'b1, 1'b1, 1'b0, 8'hA5);
    chk("fullrw_count", 32'(count), 32'd16);
    chk("fullrw_head", 32'(r_data), 32'h0A);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("drain_empty", 32'(empty), 32'd1);

    // Extra read while empty, then flush.
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00);

    // Almost-empty threshold while draining from 4.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'h00);

    // Overflow, drain to 7, then clr together with wr.
    for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("pre_clr_count", 32'(count), 32'd7);
    step(1'b1, 1'b0, 1'b1, 8'h99);
    chk_reset_vals("clr");
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Async reset in the middle of a write burst.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
    @(negedge clk);
    wr = 1'b1; w_data = 8'hFF;
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(negedge clk);
    wr = 1'b0;
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b0, 8'h77);
    chk("post_reset_head", 32'(r_data), 32'h77);
    step(1'b1, 1'b1, 1'b0, 8'h78);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
